// File: rtl/const_div_seq.sv
// ============================================================================
// Module   : const_div_seq
// Purpose  : Sequential unsigned divide-by-constant using a radix-2^CHUNK
//            remainder recurrence behind valid/ready handshakes.
//            Define CONST_DIV_REM_EN to expose the remainder port out_rem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module const_div_seq #(
   parameter int WIDTH   = 60,
   parameter int DIVISOR = 113,
   parameter int CHUNK   = 4,
   localparam int RW     = $clog2(DIVISOR),
   localparam int ITER   = WIDTH / CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef CONST_DIV_REM_EN
   output logic [RW-1:0]    out_rem,
`endif
   output logic [WIDTH-1:0] out_quot
);

   localparam int TW = RW + CHUNK;
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] r_quot;
   logic [RW-1:0]    r_rem;
   logic [CW-1:0]    r_cnt;

   logic [TW-1:0]    w_t;
   logic [TW-1:0]    w_sub;
   logic [CHUNK-1:0] w_digit;
   logic [RW-1:0]    w_rem;

   // t < DIVISOR*2^CHUNK because rem < DIVISOR, so the digit always fits.
   assign w_t = {r_rem, r_sreg[WIDTH-1 -: CHUNK]};

   // Constant-compare tree: largest k with k*DIVISOR <= t.
   always_comb begin
      w_digit = '0;
      w_sub   = '0;
      for (int k = 1; k < (1 << CHUNK); k++) begin
         if (w_t >= TW'(k * DIVISOR)) begin
            w_digit = CHUNK'(k);
            w_sub   = TW'(k * DIVISOR);
         end
      end
      w_rem = RW'(w_t - w_sub);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = RUN;
         RUN:     if (r_cnt == CW'(ITER - 1)) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sreg <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_cnt  <= '0;
      end else if (r_state == IDLE) begin
         if (in_valid) begin
            r_sreg <= in_data;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
         end
      end else if (r_state == RUN) begin
         r_sreg <= r_sreg << CHUNK;
         r_quot <= (r_quot << CHUNK) | WIDTH'(w_digit);
         r_rem  <= w_rem;
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_quot  = r_quot;
`ifdef CONST_DIV_REM_EN
   assign out_rem   = r_rem;
`endif

endmodule

`default_nettype wire
